// File: rtl/ddr_pkg.sv
// Shared DDR controller types and timing defaults for the refresh path.
package ddr_pkg;

  // Timing defaults in CK_t cycles.
  localparam int tRP  = 11;
  localparam int tRFC = 280;

  // Command presented to the command mux.
  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_PREA = 2'd1,
    CMD_REF  = 2'd2
  } ref_cmd_t;

  // Refresh sequencer states, named for waveform viewing.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_PRECHARGE,
    ST_WAIT_RP,
    ST_WAIT_RDY,
    ST_REFRESH,
    ST_WAIT_RFC,
    ST_CLEAR
  } ref_state_t;

endpackage

// File: rtl/refresh_sequencer_delay_counter.sv
// Loadable down-counter with a zero flag; stops at zero instead of wrapping.
module delay_counter
  import ddr_pkg::*;
#(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load has priority over decrement; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/refresh_sequencer.sv
// Refresh sequencer: holds off the scheduler, drains, precharges open banks,
// issues REF, waits tRFC, then pulses clear_refresh to restart the timer.
//
// state      | meaning
// IDLE       | waiting for refresh_almost / refresh_rdy
// DRAIN      | scheduler held, waiting for in-flight traffic to finish
// PRECHARGE  | PREA on the command bus for one cycle
// WAIT_RP    | tRP wait; banks must be closed at the end or PREA repeats
// WAIT_RDY   | banks closed, waiting for the timer to demand the refresh
// REFRESH    | REF on the command bus for one cycle
// WAIT_RFC   | tRFC wait, inputs ignored
// CLEAR      | one-cycle clear_refresh pulse back to the timer
module refresh_sequencer
  import ddr_pkg::*;
#(
  parameter int NUM_BANKS = 16,
  parameter int T_RP      = tRP,
  parameter int T_RFC     = tRFC,
  parameter int CNT_W     = $clog2(T_RFC + 1)
) (
  input  logic                 CK_t,
  input  logic                 reset_n,
  input  logic                 refresh_almost,
  input  logic                 refresh_rdy,
  input  logic [NUM_BANKS-1:0] bank_open,
  input  logic                 cmd_idle,
  output logic                 hold_new_cmd,
  output logic                 cmd_valid,
  output logic [1:0]           cmd_code,
  output logic                 clear_refresh,
  output logic                 refresh_busy
);

  if (T_RP < 1 || T_RFC < 1 || (T_RP - 1) >= (2 ** CNT_W)) begin : g_bad_timing
    $error("refresh_sequencer: T_RP and T_RFC must be >= 1 and fit the counter");
  end

  localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RFC_LOAD = CNT_W'(T_RFC - 1);

  ref_state_t state_q, state_d;
  ref_cmd_t   code_q, code_d;
  logic       hold_q, hold_d;
  logic       valid_q, valid_d;
  logic       clear_q, clear_d;
  logic       busy_q, busy_d;
  logic       guard_q, guard_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

  assign cnt_load     = (state_q == ST_PRECHARGE) || (state_q == ST_REFRESH);
  assign cnt_load_val = (state_q == ST_PRECHARGE) ? RP_LOAD : RFC_LOAD;
  assign cnt_dec      = (state_q == ST_WAIT_RP) || (state_q == ST_WAIT_RFC);

  delay_counter #(.CNT_W(CNT_W)) u_delay (
    .clk      (CK_t),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next state, plus outputs decoded from the next state so they line up with it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!guard_q && (refresh_almost || refresh_rdy)) state_d = ST_DRAIN;
      ST_DRAIN:     if (cmd_idle) state_d = (|bank_open) ? ST_PRECHARGE : ST_WAIT_RDY;
      ST_PRECHARGE: state_d = ST_WAIT_RP;
      ST_WAIT_RP:   if (cnt_zero) state_d = (|bank_open) ? ST_PRECHARGE : ST_WAIT_RDY;
      ST_WAIT_RDY:  if (refresh_rdy) state_d = ST_REFRESH;
      ST_REFRESH:   state_d = ST_WAIT_RFC;
      ST_WAIT_RFC:  if (cnt_zero) state_d = ST_CLEAR;
      ST_CLEAR:     state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    // The timer drops its flags one edge after the clear, so IDLE must not
    // re-trigger in the cycle right after CLEAR.
    guard_d = (state_q == ST_CLEAR);

    hold_d  = (state_d != ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    clear_d = (state_d == ST_CLEAR);
    valid_d = (state_d == ST_PRECHARGE) || (state_d == ST_REFRESH);
    code_d  = CMD_NOP;
    if (state_d == ST_PRECHARGE) code_d = CMD_PREA;
    if (state_d == ST_REFRESH)   code_d = CMD_REF;
  end

  // State and registered outputs; clear_refresh is held high through reset.
  always_ff @(posedge CK_t) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      guard_q <= 1'b0;
      hold_q  <= 1'b0;
      valid_q <= 1'b0;
      code_q  <= CMD_NOP;
      clear_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      clear_q <= clear_d;
      busy_q  <= busy_d;
    end
  end

  assign hold_new_cmd  = hold_q;
  assign cmd_valid     = valid_q;
  assign cmd_code      = code_q;
  assign clear_refresh = clear_q;
  assign refresh_busy  = busy_q;

endmodule
